// File: rtl/com_fifo_fwft_pkg.sv
// Shared helpers for the com_fifo_fwft buffer: occupancy width and
// wrap-bit pointer distance.
package com_fifo_fwft_pkg;

  // Occupancy counter covers RAM + in-flight read + 2-entry output stage.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

  // Distance between two wrap-bit pointers of width ptr_w.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                           input logic [31:0] rd,
                                           input int unsigned ptr_w);
    return (wr - rd) & ((32'd1 << ptr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/com_fifo_fwft_if.sv
// Valid/ready bus of com_fifo_fwft: write side (s_*), head side (m_*),
// flush and occupancy status.
interface com_fifo_fwft_if
  import com_fifo_fwft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              almost_empty;

  modport master (
    output flush, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, count, almost_full, almost_empty
  );

  modport slave (
    input  flush, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, count, almost_full, almost_empty
  );
endinterface

// File: rtl/com_tpram_reg.sv
// Simple two-port RAM: strobed synchronous write, registered read
// (one cycle latency). Storage is not reset.
module com_tpram_reg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int STRB_W = 1
)(
  input  logic                     i_wr_clk,
  input  logic [STRB_W-1:0]        i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data
);
  localparam int LANE_W = DATA_W / STRB_W;

  for (genvar g = 0; g < STRB_W; g++) begin : g_lane
    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [LANE_W-1:0] r_q;

    always_ff @(posedge i_wr_clk)
      if (i_wr_en[g]) r_mem[i_wr_addr] <= i_wr_data[g*LANE_W +: LANE_W];

    always_ff @(posedge i_rd_clk)
      if (i_rd_en) r_q <= r_mem[i_rd_addr];

    assign o_rd_data[g*LANE_W +: LANE_W] = r_q;
  end
endmodule

// File: rtl/com_fifo_fwft.sv
// First-word-fall-through FIFO: RAM body plus a 2-entry prefetch stage that
// hides the RAM read latency. Capacity DEPTH+2.
module com_fifo_fwft
  import com_fifo_fwft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
)(
  input  logic           clk,
  input  logic           rst_n,
  com_fifo_fwft_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = cnt_width(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_ram_cnt;
  logic              w_full, w_push, w_pop, w_rd, w_m_valid, w_head_ram;
  logic [1:0]        r_out_cnt, w_k;
  logic [2:0]        w_occ;
  logic              r_inflight;
  logic [DATA_W-1:0] r_slot0, r_slot1, w_slot0_nxt, w_slot1_nxt, w_rd_data;
  logic [CNT_W-1:0]  r_count;

  assign w_ram_cnt = PTR_W'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PTR_W));
  assign w_full    = (w_ram_cnt == PTR_W'(DEPTH));

  // The read landing in the RAM output register acts as the head whenever
  // the output stage is empty, which gives the two-cycle write-to-valid path.
  assign w_head_ram = (r_out_cnt == 2'd0) && r_inflight;
  assign w_m_valid  = (r_out_cnt != 2'd0) || r_inflight;

  assign w_push = bus.s_valid && !w_full && !bus.flush;
  assign w_pop  = w_m_valid && bus.m_ready && !bus.flush;

  // Entries owned by the output side after this cycle's pop.
  assign w_occ = {1'b0, r_out_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rd  = (w_ram_cnt != '0) && (w_occ < 3'd2) && !bus.flush;

  com_tpram_reg #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .STRB_W (1)
  ) u_ram (
    .i_wr_clk  (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (bus.s_data),
    .i_rd_clk  (clk),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Shift on pop, then drop the arriving read into the first free slot,
  // unless that read was itself consumed straight from the RAM register.
  always_comb begin
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    w_k         = r_out_cnt;
    if (w_pop && r_out_cnt != 2'd0) begin
      w_slot0_nxt = r_slot1;
      w_k         = r_out_cnt - 2'd1;
    end
    if (r_inflight && !(w_pop && w_head_ram)) begin
      if (w_k == 2'd0) w_slot0_nxt = w_rd_data;
      else             w_slot1_nxt = w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_slot0    <= '0;
      r_slot1    <= '0;
    end else if (bus.flush) begin
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
      r_slot0    <= '0;
      r_slot1    <= '0;
    end else begin
      r_out_cnt  <= w_occ[1:0];
      r_inflight <= w_rd;
      r_slot0    <= w_slot0_nxt;
      r_slot1    <= w_slot1_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= '0;
    else if (bus.flush)        r_count <= '0;
    else if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
    else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
  end

  assign bus.s_ready      = !w_full;
  assign bus.m_valid      = w_m_valid;
  assign bus.m_data       = w_head_ram ? w_rd_data : r_slot0;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= CNT_W'(AF_LVL));
  assign bus.almost_empty = (r_count <= CNT_W'(AE_LVL));

  a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_rd && (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0])));

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.m_valid && !bus.m_ready && !bus.flush) |=> $stable(bus.m_data));

endmodule
